seq_bit_serializer: RTL
=======================

// Module: seq_bit_serializer
// PURPOSE
// - Upstream feeder for the 101 sequence detector: accepts parallel words over a valid/ready handshake.
// - Shifts each word out one bit per clock on d_out, which drives the detector's d_in.
// - Flags each live bit with d_valid and pulses done on the last bit of every word.
// - Optional idle gap between words so detector tests can separate frames.
// PARAMETERS
// - WIDTH       8     bits per word; legal range 2..32
// - MSB_FIRST   1     1 = shift bit WIDTH-1 first; 0 = shift bit 0 first
// - GAP_CYCLES  0     idle cycles inserted after each word; legal range 0..15
// - IDLE_BIT    1'b0  level driven on d_out whenever d_valid=0
// PORTS
// - clock       in   1      rising-edge clock
// - rst         in   1      synchronous active-high reset
// - data_in     in   WIDTH  word to serialize; sampled only on an accept
// - load_valid  in   1      producer offers data_in
// - load_ready  out  1      serializer can accept a word this cycle
// - d_out       out  1      serial bit; connects to detector d_in
// - d_valid     out  1      d_out carries a data bit this cycle
// - busy        out  1      state != IDLE
// - done        out  1      one-cycle pulse, coincident with the last bit of a word
// BEHAVIOUR
// - Reset: clock and reset are one clock; reset is synchronous and active-high.
//   - rst=1 at a rising edge gives state=IDLE, shift register=0, bit counter=0, gap counter=0.
//   - Registered outputs after that edge: d_out=IDLE_BIT, d_valid=0, done=0.
//   - busy=0 and load_ready=1 follow combinationally from IDLE.
//   - rst takes priority over every other input.
//   - rst asserted mid-word aborts the word: no done pulse, remaining bits discarded.
// - Accept: occurs when load_valid && load_ready at a rising edge. Register data_in at that edge.
// - Latency: the first bit appears on d_out with d_valid=1 in the cycle after the accept edge.
// - State machine (2-bit encoding):
//   - IDLE: d_valid=0, d_out=IDLE_BIT, load_ready=1. On accept, go to SHIFT with bit counter=WIDTH-1.
//   - SHIFT: d_valid=1; d_out = current MSB (or LSB when MSB_FIRST=0). Shift and decrement the counter each cycle.
//     - Counter==0 marks the last bit; done=1 in that same cycle.
//     - After the last bit with GAP_CYCLES>0, go to GAP with gap counter=GAP_CYCLES-1.
//     - After the last bit with GAP_CYCLES==0 and an accept in that cycle, reload and stay in SHIFT (zero-bubble streaming).
//     - After the last bit with GAP_CYCLES==0 and no accept, go to IDLE.
//   - GAP: d_valid=0, d_out=IDLE_BIT, load_ready=0. Go to IDLE when the gap counter reaches 0.
// - load_ready = (state==IDLE) || (state==SHIFT && counter==0 && GAP_CYCLES==0).
// - Word timing: exactly WIDTH consecutive d_valid cycles per accepted word; no stutter or repeat.
// - load_valid while load_ready=0: ignored; data_in is not sampled and no state changes.
// - data_in changing during SHIFT has no effect.
// - Bit counter width: $clog2(WIDTH). Gap counter: 4 bits. No arithmetic overflow is possible within legal parameter ranges.
// - d_out and d_valid are registered, glitch-free, and change only on rising clock edges.
// STRUCTURE
// - Shared package seq_pkg holds:
//   - state constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2
//   - default width constant SEQ_WORD_W=8
//   - IDLE_BIT default
// - Sub-module seq_shift_reg(WIDTH, MSB_FIRST) with ports clock, rst, load, shift, d, q_bit.
//   - Top level keeps the FSM, counters and handshake.
// - The detector instance stays outside this block; the integration bench wires d_out to d_in.
// TESTING
// - Reset: hold rst=1 for 2 cycles with load_valid=1.
//   -> d_valid=0, busy=0, load_ready=1, done=0, d_out=0; no word accepted.
// - Single word: WIDTH=8, MSB_FIRST=1, data_in=8'hB5, one-cycle accept.
//   -> d_out=1,0,1,1,0,1,0,1 on 8 consecutive d_valid cycles.
//   -> done on the 8th bit.
//   -> Attached detector pulses found 3 times.
// - LSB-first plus gap: MSB_FIRST=0, GAP_CYCLES=3, data_in=8'h0D.
//   -> Bits 1,0,1,1,0,0,0,0, then 3 cycles with d_valid=0 and load_ready=0.
//   -> load_ready returns on the 4th cycle after done.
// - Back-to-back: GAP_CYCLES=0, load_valid held high with 8'hA5 then 8'h5A.
//   -> 16 consecutive d_valid cycles, no bubble.
//   -> done pulses at bit 8 and bit 16.
// - Backpressure: pulse load_valid with 8'hFF at bit 3 of word 8'h00.
//   -> Request ignored; stream stays 0x00.
//   -> Exactly one done pulse; busy drops after 8 bits.
// - Abort: assert rst during bit 4 of 8'hB5.
//   -> Next cycle d_valid=0 and busy=0; done never pulses.
//   -> A fresh accept of 8'h01 then emits 0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared state encoding and defaults for the 101-detector feeder.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_e;

    localparam int   SEQ_WORD_W   = 8;
    localparam logic SEQ_IDLE_BIT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/seq_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_reg
// Purpose  : Parallel-load shift register with a registered serial output bit.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_reg
    import seq_pkg::*;
#(
    parameter int   WIDTH     = SEQ_WORD_W,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL_BIT  = SEQ_IDLE_BIT
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_bit
);

    // r_bit is the bit on the wire now; r_word holds the bits still to come,
    // backfilled with FILL_BIT so the shift after the last bit idles the line.
    logic [WIDTH-1:0] r_word;
    logic             r_bit;
    logic             w_load_bit;
    logic             w_shift_bit;
    logic [WIDTH-1:0] w_load_word;
    logic [WIDTH-1:0] w_shift_word;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_bit   = d[WIDTH-1];
            assign w_load_word  = {d[WIDTH-2:0], FILL_BIT};
            assign w_shift_bit  = r_word[WIDTH-1];
            assign w_shift_word = {r_word[WIDTH-2:0], FILL_BIT};
        end else begin : g_lsb_first
            assign w_load_bit   = d[0];
            assign w_load_word  = {FILL_BIT, d[WIDTH-1:1]};
            assign w_shift_bit  = r_word[0];
            assign w_shift_word = {FILL_BIT, r_word[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (rst) begin
            r_word <= '0;
            r_bit  <= FILL_BIT;
        end else if (load) begin
            r_word <= w_load_word;
            r_bit  <= w_load_bit;
        end else if (shift) begin
            r_word <= w_shift_word;
            r_bit  <= w_shift_bit;
        end
    end

    assign q_bit = r_bit;

endmodule
`default_nettype wire

// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_serializer
// Purpose  : Valid/ready word intake, one bit per clock out to the detector.
// Revision : 1.0 - initial release
// ============================================================================
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = SEQ_WORD_W,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = SEQ_IDLE_BIT
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [3:0]      c_gap_load = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic            c_stream   = (GAP_CYCLES == 0);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [3:0]       r_gap_cnt;
    logic [3:0]       w_gap_cnt_nxt;
    logic             r_d_valid;
    logic             r_done;
    logic             w_last;
    logic             w_accept;
    logic             w_shift;

    assign w_last     = (r_state == ST_SHIFT) && (r_bit_cnt == '0);
    assign load_ready = (r_state == ST_IDLE) || (w_last && c_stream);
    assign w_accept   = load_valid && load_ready;
    assign w_shift    = (r_state == ST_SHIFT);

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_cnt_nxt = c_cnt_last;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = c_gap_load;
                    end else if (w_accept) begin
                        w_bit_cnt_nxt = c_cnt_last;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Flags are registered from next-state so they line up with the bit the
    // shift register presents in the same cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= 4'd0;
            r_d_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_d_valid <= (w_state_nxt == ST_SHIFT);
            r_done    <= (w_state_nxt == ST_SHIFT) && (w_bit_cnt_nxt == '0);
        end
    end

    seq_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .FILL_BIT  (IDLE_BIT)
    ) u_shift_reg (
        .clock (clock),
        .rst   (rst),
        .load  (w_accept),
        .shift (w_shift),
        .d     (data_in),
        .q_bit (d_out)
    );

    assign d_valid = r_d_valid;
    assign done    = r_done;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire
